// File: rtl/jg3_pkg.sv
// Shared types and constants for the three-judge vote collector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jg3_pkg;

    localparam int NUM_JUDGES = 3;

    // Bit positions of each judge inside the vote word abc.
    localparam int JUDGE_A = 2;
    localparam int JUDGE_B = 1;
    localparam int JUDGE_C = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EVAL    = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic pass;
        logic none;
    } decision_t;

endpackage

// File: rtl/jg3_vote_collector_if.sv
// Handshake and result bundle between judge front end, collector and display logic.
// Latency: n/a (wires only).
// Backpressure: votes are held by the judge side until vote_ack; results are strobed, never stalled.
interface jg3_vote_collector_if;
    import jg3_pkg::*;

    logic                  start;
    logic [NUM_JUDGES-1:0] vote_valid;
    logic [NUM_JUDGES-1:0] vote_val;
    logic [NUM_JUDGES-1:0] vote_ack;
    logic                  busy;
    logic [NUM_JUDGES-1:0] abc;
    logic                  pass;
    logic                  none;
    logic                  timed_out;
    logic                  result_valid;

    // Judge/display side: drives requests and votes, observes acks and results.
    modport master (
        output start, vote_valid, vote_val,
        input  vote_ack, busy, abc, pass, none, timed_out, result_valid
    );

    // Collector side.
    modport slave (
        input  start, vote_valid, vote_val,
        output vote_ack, busy, abc, pass, none, timed_out, result_valid
    );

endinterface

// File: rtl/jg3_vote_decode.sv
// Combinational decision: abc -> {pass, none}.
// Latency: 0 cycles.
// Backpressure: none, pure logic.
module jg3_vote_decode
    import jg3_pkg::*;
(
    input  logic [NUM_JUDGES-1:0] abc,
    output decision_t             dec
);

    // Judge C holds a veto: pass needs C plus at least one of A or B.
    assign dec.pass = abc[JUDGE_C] & (abc[JUDGE_A] | abc[JUDGE_B]);
    assign dec.none = (abc == '0);

endmodule

// File: rtl/jg3_vote_collector.sv
// Opens a voting window on start, collects one vote per judge, decides, strobes result_valid.
// Latency: result_valid is high in the second cycle after the edge that samples the last vote.
// Backpressure: judges hold vote_valid until acked; start while busy is dropped.
module jg3_vote_collector
    import jg3_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    jg3_vote_collector_if.slave bus
);

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [NUM_JUDGES-1:0] ALL_VOTED = '1;

    state_t                state, state_nxt;
    logic [NUM_JUDGES-1:0] voted, voted_nxt;
    logic [NUM_JUDGES-1:0] votes, votes_nxt;
    logic [NUM_JUDGES-1:0] accept;
    logic [NUM_JUDGES-1:0] ack, ack_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  to_pend, to_pend_nxt;
    logic [NUM_JUDGES-1:0] abc_q, abc_nxt;
    logic                  pass_q, pass_nxt;
    logic                  none_q, none_nxt;
    logic                  to_q, to_nxt;
    logic                  rv_q, rv_nxt;
    decision_t             dec;

    // Decision is computed from the live vote register and captured in EVAL.
    jg3_vote_decode u_decode (
        .abc (votes),
        .dec (dec)
    );

    // Next-state, vote acceptance, timeout and result capture.
    always_comb begin
        state_nxt   = state;
        voted_nxt   = voted;
        votes_nxt   = votes;
        accept      = '0;
        ack_nxt     = '0;
        cnt_nxt     = cnt;
        to_pend_nxt = to_pend;
        abc_nxt     = abc_q;
        pass_nxt    = pass_q;
        none_nxt    = none_q;
        to_nxt      = to_q;
        rv_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = COLLECT;
                    voted_nxt = '0;
                    votes_nxt = '0;
                    cnt_nxt   = '0;
                end
            end

            COLLECT: begin
                // First vote per judge is final; repeats are neither latched nor acked.
                accept    = bus.vote_valid & ~voted;
                ack_nxt   = accept;
                voted_nxt = voted | accept;
                votes_nxt = votes | (accept & bus.vote_val);
                cnt_nxt   = cnt + CNT_ONE;
                // A full set wins over the timeout, even in the timeout cycle itself.
                if ((voted | accept) == ALL_VOTED) begin
                    state_nxt   = EVAL;
                    to_pend_nxt = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = EVAL;
                    to_pend_nxt = 1'b1;
                end
            end

            EVAL: begin
                abc_nxt   = votes;
                pass_nxt  = dec.pass;
                none_nxt  = dec.none;
                to_nxt    = to_pend;
                rv_nxt    = 1'b1;
                state_nxt = DONE;
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            voted   <= '0;
            votes   <= '0;
            ack     <= '0;
            cnt     <= '0;
            to_pend <= 1'b0;
            abc_q   <= '0;
            pass_q  <= 1'b0;
            none_q  <= 1'b0;
            to_q    <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            voted   <= voted_nxt;
            votes   <= votes_nxt;
            ack     <= ack_nxt;
            cnt     <= cnt_nxt;
            to_pend <= to_pend_nxt;
            abc_q   <= abc_nxt;
            pass_q  <= pass_nxt;
            none_q  <= none_nxt;
            to_q    <= to_nxt;
            rv_q    <= rv_nxt;
        end
    end

    assign bus.vote_ack     = ack;
    assign bus.busy         = (state != IDLE);
    assign bus.abc          = abc_q;
    assign bus.pass         = pass_q;
    assign bus.none         = none_q;
    assign bus.timed_out    = to_q;
    assign bus.result_valid = rv_q;

endmodule

// File: tb/tb_jg3_vote_collector.sv
// Self-checking bench for jg3_vote_collector: vote table plus reset/idle corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_jg3_vote_collector;
    import jg3_pkg::*;

    localparam int T = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jg3_vote_collector_if vif ();

    jg3_vote_collector #(
        .TIMEOUT_CYCLES (T),
        .CNT_W          (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    // Per-window stimulus: four COLLECT-relative cycles, element [0] is the first cycle.
    typedef struct packed {
        logic [3:0][2:0] vv;
        logic [3:0][2:0] vl;
        logic [3:0][2:0] ack;
        logic [2:0]      abc;
        logic            pass;
        logic            none;
        logic            to;
        int              rv;   // edge index (after COLLECT entry) where result_valid is seen
    } vec_t;

    typedef struct packed {
        logic [2:0] abc;
        logic       pass;
        logic       none;
        logic       to;
    } res_t;

    int   checks   = 0;
    int   failures = 0;
    res_t exp_q[$];
    res_t mon_r;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input logic [11:0] vv, input logic [11:0] vl,
                                input logic [11:0] ack, input logic [2:0] abc,
                                input logic p, input logic n, input logic t, input int rv);
        vec_t v;
        v.vv = vv; v.vl = vl; v.ack = ack;
        v.abc = abc; v.pass = p; v.none = n; v.to = t; v.rv = rv;
        return v;
    endfunction

    // Scoreboard: every result strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && vif.result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_r = exp_q.pop_front();
                chk("abc",       32'(vif.abc),       32'(mon_r.abc));
                chk("pass",      32'(vif.pass),      32'(mon_r.pass));
                chk("none",      32'(vif.none),      32'(mon_r.none));
                chk("timed_out", 32'(vif.timed_out), 32'(mon_r.to));
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},  32'(vif.vote_ack),     32'd0);
        chk({tag, "_busy"}, 32'(vif.busy),         32'd0);
        chk({tag, "_abc"},  32'(vif.abc),          32'd0);
        chk({tag, "_pass"}, 32'(vif.pass),         32'd0);
        chk({tag, "_none"}, 32'(vif.none),         32'd0);
        chk({tag, "_to"},   32'(vif.timed_out),    32'd0);
        chk({tag, "_rv"},   32'(vif.result_valid), 32'd0);
    endtask

    initial begin
        int seen;
        vif.start      = 1'b0;
        vif.vote_valid = '0;
        vif.vote_val   = '0;

        // Cycle fields are written {c3, c2, c1, c0}.
        vecs[0] = mk({3'b000,3'b001,3'b010,3'b100}, {3'b000,3'b001,3'b000,3'b100},
                     {3'b000,3'b001,3'b010,3'b100}, 3'b101, 1, 0, 0, 4);
        vecs[1] = mk({3'b111,3'b111,3'b000,3'b111}, {3'b111,3'b111,3'b000,3'b110},
                     {3'b000,3'b000,3'b000,3'b111}, 3'b110, 0, 0, 0, 2);
        vecs[2] = mk({3'b100,3'b010,3'b001,3'b001}, {3'b000,3'b010,3'b000,3'b001},
                     {3'b100,3'b010,3'b000,3'b001}, 3'b011, 1, 0, 0, 5);
        vecs[3] = mk({3'b000,3'b000,3'b010,3'b000}, {3'b000,3'b000,3'b010,3'b000},
                     {3'b000,3'b000,3'b010,3'b000}, 3'b010, 0, 0, 1, 5);
        vecs[4] = mk(12'd0, 12'd0, 12'd0, 3'b000, 0, 1, 1, 5);
        vecs[5] = mk({3'b100,3'b000,3'b000,3'b011}, {3'b100,3'b000,3'b000,3'b011},
                     {3'b100,3'b000,3'b000,3'b011}, 3'b111, 1, 0, 0, 5);
        vecs[6] = mk({3'b000,3'b000,3'b101,3'b010}, {3'b000,3'b000,3'b000,3'b111},
                     {3'b000,3'b000,3'b101,3'b010}, 3'b010, 0, 0, 0, 3);
        vecs[7] = mk({3'b000,3'b100,3'b000,3'b001}, {3'b000,3'b100,3'b000,3'b001},
                     {3'b000,3'b100,3'b000,3'b001}, 3'b101, 1, 0, 1, 5);

        // Reset state.
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Votes while idle get no ack and do not open a window.
        @(negedge clk);
        vif.vote_valid = 3'b111;
        vif.vote_val   = 3'b111;
        @(negedge clk);
        chk("idle_ack", 32'(vif.vote_ack), 32'd0);
        @(negedge clk);
        chk("idle_ack2", 32'(vif.vote_ack), 32'd0);
        chk("idle_busy", 32'(vif.busy), 32'd0);
        vif.vote_valid = '0;
        vif.vote_val   = '0;

        // Table-driven windows.
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{abc: vecs[i].abc, pass: vecs[i].pass,
                              none: vecs[i].none, to: vecs[i].to});
            vif.start = 1'b1;
            @(negedge clk);
            chk("busy_after_start", 32'(vif.busy), 32'd1);
            for (int k = 1; k <= 7; k++) begin
                vif.vote_valid = (k - 1 < 4) ? vecs[i].vv[k-1] : 3'b000;
                vif.vote_val   = (k - 1 < 4) ? vecs[i].vl[k-1] : 3'b000;
                // A start while busy must be ignored.
                vif.start      = (k == 2);
                @(negedge clk);
                chk($sformatf("v%0d_ack_c%0d", i, k - 1), 32'(vif.vote_ack),
                    32'((k - 1 < 4) ? vecs[i].ack[k-1] : 3'b000));
                chk($sformatf("v%0d_rv_e%0d", i, k), 32'(vif.result_valid),
                    32'(k == vecs[i].rv));
            end
            vif.start      = 1'b0;
            vif.vote_valid = '0;
            vif.vote_val   = '0;
            chk($sformatf("v%0d_idle_after", i), 32'(vif.busy), 32'd0);
        end

        // Reset mid-window after two votes: everything clears at once.
        vif.start = 1'b1;
        @(negedge clk);
        vif.start      = 1'b0;
        vif.vote_valid = 3'b001;
        vif.vote_val   = 3'b001;
        @(negedge clk);
        vif.vote_valid = 3'b010;
        vif.vote_val   = 3'b010;
        @(negedge clk);
        chk("pre_reset_ack", 32'(vif.vote_ack), 32'd2);
        vif.vote_valid = '0;
        vif.vote_val   = '0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh window after reset: only judge 2 votes, then timeout.
        exp_q.push_back('{abc: 3'b100, pass: 1'b0, none: 1'b0, to: 1'b1});
        vif.start = 1'b1;
        @(negedge clk);
        vif.start      = 1'b0;
        vif.vote_valid = 3'b100;
        vif.vote_val   = 3'b100;
        @(negedge clk);
        chk("post_reset_ack", 32'(vif.vote_ack), 32'd4);
        vif.vote_valid = '0;
        vif.vote_val   = '0;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(negedge clk);
            if (vif.result_valid === 1'b1) seen = 1;
        end
        chk("post_reset_result_seen", 32'(seen), 32'd1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
